// File: rtl/dram_rd_pkg.sv
// Shared types and constants for the DRAM burst reader: FSM states, AXI
// encodings and the 4 KB burst-boundary test.
package dram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHK,
        ADDR,
        DATA
    } state_t;

    localparam logic [2:0]  AXSIZE_4B   = 3'b010;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam int unsigned BOUNDARY_4K = 4096;

    // One past the last byte of the burst, measured from the start of its 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] offset, input logic [3:0] len);
        logic [12:0] end_byte;
        end_byte = {1'b0, offset} + {7'd0, len, 2'b00} + 13'd4;
        return 32'(end_byte) > BOUNDARY_4K;
    endfunction

endpackage

// File: rtl/dram_burst_reader_if.sv
// Bundle of the request, AXI read (AR/R) and output-stream signals of the
// burst reader; master is the reader side, slave is the environment side.
interface dram_burst_reader_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            req_len;

    logic [ID_WIDTH-1:0]   arid_m_inf;
    logic [ADDR_WIDTH-1:0] araddr_m_inf;
    logic [3:0]            arlen_m_inf;
    logic [2:0]            arsize_m_inf;
    logic [1:0]            arburst_m_inf;
    logic                  arvalid_m_inf;
    logic                  arready_m_inf;

    logic [ID_WIDTH-1:0]   rid_m_inf;
    logic [DATA_WIDTH-1:0] rdata_m_inf;
    logic [1:0]            rresp_m_inf;
    logic                  rlast_m_inf;
    logic                  rvalid_m_inf;
    logic                  rready_m_inf;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  done;
    logic                  err;

    modport master (
        input  req_valid, req_addr, req_len,
        output req_ready,
        output arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
        input  arready_m_inf,
        input  rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
        output rready_m_inf,
        output out_valid, out_data, out_last,
        input  out_ready,
        output done, err
    );

    modport slave (
        output req_valid, req_addr, req_len,
        input  req_ready,
        input  arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
        output arready_m_inf,
        output rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
        input  rready_m_inf,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  done, err
    );

endinterface

// File: rtl/dram_rd_fifo.sv
// Synchronous FIFO between the R channel and the output stream; the head
// entry is presented combinationally and a full FIFO accepts a push when popped.
module dram_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dram_burst_reader.sv
// AXI4 read initiator: fetches one INCR burst of 32-bit words per request and
// streams the words out through a small FIFO, reporting completion and errors.
module dram_burst_reader
    import dram_rd_pkg::*;
#(
    parameter int                  ID_WIDTH   = 4,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0,
    parameter int                  FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dram_burst_reader_if.master bus
);

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [4:0]            beat_cnt;
    logic                  err_acc;
    logic                  done_q;
    logic                  err_q;

    logic                  req_ready;
    logic                  arvalid;
    logic                  rready;
    logic                  req_fire;
    logic                  beat_fire;
    logic                  beat_err;
    logic                  burst_bad;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_dout;

    assign burst_bad = crosses_4k(addr_q[11:0], len_q);
    assign req_fire  = req_ready && bus.req_valid;
    assign beat_fire = rready && bus.rvalid_m_inf;

    // Protocol and response checks on every accepted beat.
    assign beat_err = (bus.rresp_m_inf != RESP_OKAY)
                   || (bus.rid_m_inf != AXI_ID)
                   || ( bus.rlast_m_inf && (beat_cnt != {1'b0, len_q}))
                   || (!bus.rlast_m_inf && (beat_cnt == {1'b0, len_q}));

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst_n && fifo_empty;
                if (req_ready && bus.req_valid) state_nx = CHK;
            end
            CHK: begin
                state_nx = burst_bad ? IDLE : ADDR;
            end
            ADDR: begin
                arvalid = 1'b1;
                if (bus.arready_m_inf) state_nx = DATA;
            end
            DATA: begin
                rready = !fifo_full;
                if (rready && bus.rvalid_m_inf && bus.rlast_m_inf) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            err_acc  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (req_fire) begin
                addr_q   <= bus.req_addr & ~ADDR_WIDTH'(3);
                len_q    <= bus.req_len;
                beat_cnt <= '0;
                err_acc  <= 1'b0;
            end
            if (state == CHK && burst_bad) begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
            end
            if (beat_fire) begin
                // Saturate so over-long bursts can never wrap back onto len.
                if (beat_cnt != 5'd31) beat_cnt <= beat_cnt + 5'd1;
                err_acc <= err_acc | beat_err;
                if (bus.rlast_m_inf) begin
                    done_q <= 1'b1;
                    err_q  <= err_acc | beat_err;
                end
            end
        end
    end

    dram_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (beat_fire),
        .din   ({bus.rlast_m_inf, bus.rdata_m_inf}),
        .pop   (bus.out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.req_ready     = req_ready;
    assign bus.arid_m_inf    = AXI_ID;
    assign bus.araddr_m_inf  = addr_q;
    assign bus.arlen_m_inf   = len_q;
    assign bus.arsize_m_inf  = AXSIZE_4B;
    assign bus.arburst_m_inf = BURST_INCR;
    assign bus.arvalid_m_inf = arvalid;
    assign bus.rready_m_inf  = rready;
    assign bus.out_valid     = !fifo_empty;
    assign bus.out_data      = fifo_dout[DATA_WIDTH-1:0];
    assign bus.out_last      = fifo_dout[DATA_WIDTH];
    assign bus.done          = done_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_dram_burst_reader.sv
// Scoreboard bench for dram_burst_reader: a DRAM read responder answers AR/R,
// expected words are queued at request time and compared as they stream out.
module tb_dram_burst_reader;

    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [32:0] exp_q [$];

    int          cfg_beats;
    int          cfg_err_beat;
    int          cfg_ar_stall;
    logic [3:0]  cfg_rid;
    logic [31:0] exp_araddr;
    logic [3:0]  exp_arlen;
    int          beats_acc;
    int          ar_cnt;
    int          arv_rise_cyc;
    int          last_beat_cyc;
    int          acc_cyc;
    int          done_cyc;
    bit          arv_seen;

    dram_burst_reader_if #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) bus ();

    dram_burst_reader #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AXI_ID     (4'd0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dram_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // DRAM read port: answers AR after an optional stall, then returns beats.
    initial begin
        int          beat;
        int          stall_left;
        logic [31:0] r_addr;
        bit          phase;
        beat = 0; stall_left = 0; r_addr = '0; phase = 1'b0;
        bus.arready_m_inf = 1'b0;
        bus.rvalid_m_inf  = 1'b0;
        bus.rid_m_inf     = '0;
        bus.rdata_m_inf   = '0;
        bus.rresp_m_inf   = 2'b00;
        bus.rlast_m_inf   = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (rst_n) begin
                phase = 1'b0;
                arv_seen = 1'b0;
                bus.arready_m_inf = 1'b0;
                bus.rvalid_m_inf  = 1'b0;
                bus.rlast_m_inf   = 1'b0;
            end else if (!phase) begin
                bus.rvalid_m_inf = 1'b0;
                bus.rlast_m_inf  = 1'b0;
                if (bus.arvalid_m_inf) begin
                    if (!arv_seen) begin
                        arv_seen     = 1'b1;
                        arv_rise_cyc = cyc;
                        stall_left   = cfg_ar_stall;
                    end
                    if (stall_left > 0) begin
                        bus.arready_m_inf = 1'b0;
                        stall_left--;
                    end else begin
                        bus.arready_m_inf = 1'b1;
                        check("araddr", bus.araddr_m_inf, exp_araddr);
                        check("arlen", bus.arlen_m_inf, exp_arlen);
                        check("ar_const", {bus.arsize_m_inf, bus.arburst_m_inf, bus.arid_m_inf},
                              {3'b010, 2'b01, 4'd0});
                        r_addr   = bus.araddr_m_inf;
                        ar_cnt++;
                        arv_seen = 1'b0;
                        phase    = 1'b1;
                        beat     = 0;
                    end
                end else begin
                    bus.arready_m_inf = 1'b0;
                end
            end else begin
                bus.arready_m_inf = 1'b0;
                bus.rvalid_m_inf  = 1'b1;
                bus.rdata_m_inf   = dram_word(r_addr + 32'(4 * beat));
                bus.rresp_m_inf   = (beat == cfg_err_beat) ? 2'b10 : 2'b00;
                bus.rid_m_inf     = cfg_rid;
                bus.rlast_m_inf   = (beat == cfg_beats - 1);
                if (bus.rready_m_inf) begin
                    beats_acc++;
                    if (beat == cfg_beats - 1) begin
                        last_beat_cyc = cyc + 1;
                        phase = 1'b0;
                    end
                    beat++;
                end
            end
        end
    end

    // Output monitor: every delivered word is popped from the scoreboard.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk); #1;
            if (!rst_n && bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", {bus.out_last, bus.out_data}, e);
                end
            end
        end
    end

    task automatic send_req(input logic [31:0] a, input logic [3:0] l);
        int n;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", bus.req_ready, 1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic start_burst(input logic [31:0] a, input logic [3:0] l, input int beats,
                               input int err_beat, input logic [3:0] rid, input int stall);
        logic [31:0] base;
        base         = {a[31:2], 2'b00};
        cfg_beats    = beats;
        cfg_err_beat = err_beat;
        cfg_rid      = rid;
        cfg_ar_stall = stall;
        exp_araddr   = base;
        exp_arlen    = l;
        beats_acc    = 0;
        for (int i = 0; i < beats; i++)
            exp_q.push_back({i == beats - 1, dram_word(base + 32'(4 * i))});
        send_req(a, l);
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n;
        n = 0;
        while (!bus.done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_err"}, bus.err, exp_err);
        done_cyc = cyc;
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_out_idle"}, bus.out_valid, 0);
    endtask

    initial begin
        int n;
        int arc0;
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.out_ready = 1'b1;
        cfg_beats = 1; cfg_err_beat = -1; cfg_ar_stall = 0; cfg_rid = '0;
        exp_araddr = '0; exp_arlen = '0; beats_acc = 0; ar_cnt = 0;
        arv_rise_cyc = 0; last_beat_cyc = 0; acc_cyc = 0; done_cyc = 0;

        repeat (3) @(negedge clk);
        check("rst_ctrl", {bus.req_ready, bus.arvalid_m_inf, bus.rready_m_inf,
                           bus.out_valid, bus.done, bus.err}, 0);
        check("rst_payload", {bus.araddr_m_inf, bus.arlen_m_inf, bus.arid_m_inf}, 0);
        check("rst_const", {bus.arsize_m_inf, bus.arburst_m_inf}, {3'b010, 2'b01});
        rst_n = 1'b0;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1);

        // Basic 16-beat burst
        start_burst(32'h0001_0000, 4'd15, 16, -1, 4'd0, 0);
        wait_done("basic", 1'b0);
        check("basic_ar_rise", arv_rise_cyc, acc_cyc + 1);
        check("basic_done_lat", done_cyc, last_beat_cyc);
        drain("basic");

        // 4 KB crossing: no AR, error two cycles after acceptance
        arc0 = ar_cnt;
        send_req(32'h0000_0FF8, 4'd3);
        wait_done("x4k", 1'b1);
        check("x4k_lat", done_cyc, acc_cyc + 1);
        check("x4k_no_ar", ar_cnt - arc0, 0);

        // Back-pressure
        bus.out_ready = 1'b0;
        start_burst(32'h0002_0040, 4'd7, 8, -1, 4'd0, 0);
        repeat (9) @(negedge clk);
        check("bp_beats", beats_acc, 4);
        check("bp_rready", bus.rready_m_inf, 0);
        check("bp_head", {bus.out_valid, bus.out_data}, {1'b1, dram_word(32'h0002_0040)});
        bus.out_ready = 1'b1;
        wait_done("bp", 1'b0);
        drain("bp");

        // SLVERR on beat 0
        start_burst(32'h0000_1100, 4'd1, 2, 0, 4'd0, 0);
        wait_done("resp", 1'b1);
        drain("resp");

        // rlast one beat early
        start_burst(32'h0000_2200, 4'd3, 3, -1, 4'd0, 0);
        wait_done("early", 1'b1);
        drain("early");

        // Wrong rid, unaligned request address
        start_burst(32'h0000_3307, 4'd0, 1, -1, 4'd5, 0);
        wait_done("rid", 1'b1);
        drain("rid");

        // Beats beyond the expected count are still delivered
        start_burst(32'h0000_4400, 4'd0, 3, -1, 4'd0, 0);
        wait_done("extra", 1'b1);
        drain("extra");

        // AR stall on a burst ending exactly at the 4 KB boundary
        start_burst(32'h0004_0FC0, 4'd15, 16, -1, 4'd0, 20);
        n = 0;
        while (!bus.arvalid_m_inf && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            check("ar_hold", {bus.arvalid_m_inf, bus.araddr_m_inf, bus.arlen_m_inf},
                  {1'b1, exp_araddr, exp_arlen});
            @(negedge clk);
        end
        wait_done("stall", 1'b0);
        drain("stall");

        // Reset during DATA, then a fresh single-beat burst
        start_burst(32'h0005_0000, 4'd7, 8, -1, 4'd0, 0);
        n = 0;
        while (beats_acc < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_beats", beats_acc >= 3, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ctrl", {bus.req_ready, bus.arvalid_m_inf, bus.rready_m_inf,
                               bus.out_valid, bus.done, bus.err}, 0);
        check("mid_rst_payload", {bus.araddr_m_inf, bus.arlen_m_inf}, 0);
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.req_ready, 1);
        start_burst(32'h0005_1000, 4'd0, 1, -1, 4'd0, 0);
        wait_done("post_rst", 1'b0);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dram_burst_reader.md
# dram_burst_reader

AXI4 read-channel initiator that fetches one incremental burst of 32-bit words from a DRAM read port and delivers the words as a valid/ready stream. It sits between the instruction/data fetch controller and a read-only DRAM port; it is the requesting end of the AR/R handshake that the DRAM read model answers. One burst is in flight at a time, and a small FIFO absorbs consumer back-pressure.

## Interface
- `ID_WIDTH`, 4: AXI ID width.
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: beat width; fixed at 32, so `arsize` is 3'b010.
- `AXI_ID`, 0: constant value driven on `arid`.
- `FIFO_DEPTH`, 4: output buffer depth in words; must be a power of 2 and at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-high reset. Despite the codebase's port name, 1 means reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_addr` in ADDR_WIDTH: start byte address; bits [1:0] are ignored and forced to 0.
- `req_len` in 4: number of beats minus 1, giving 1 to 16 words.
- `arid_m_inf` out ID_WIDTH, `araddr_m_inf` out ADDR_WIDTH, `arlen_m_inf` out 4, `arsize_m_inf` out 3, `arburst_m_inf` out 2: AXI read-address payload.
- `arvalid_m_inf` out 1, `arready_m_inf` in 1: read-address handshake.
- `rid_m_inf` in ID_WIDTH, `rdata_m_inf` in DATA_WIDTH, `rresp_m_inf` in 2, `rlast_m_inf` in 1: read-data payload.
- `rvalid_m_inf` in 1, `rready_m_inf` out 1: read-data handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_WIDTH, `out_last` out 1: word stream.
- `done` out 1: one-cycle pulse when a transaction ends.
- `err` out 1: valid only while `done`=1.

## Operation
States: IDLE, CHK, ADDR, DATA.

- **IDLE:** `req_ready` = 1 only when the FIFO is empty. On `req_valid && req_ready`, the block latches the address and length, then moves to CHK.
- **CHK:** lasts one cycle.
  - If the burst crosses a 4 KB boundary (`addr[11:0] + 4*(len+1) > 4096`), the block pulses `done` with `err`=1, issues no AR, and returns to IDLE.
  - Otherwise it moves to ADDR.
- **ADDR:** `arvalid` = 1 with the payload held stable until `arready`. Payload is `arlen`=len, `arsize`=2, `arburst`=2'b01, `arid`=AXI_ID. After the handshake, the block moves to DATA.
- **DATA:**
  - `rready_m_inf` = !fifo_full.
  - Each accepted beat is pushed to the FIFO and increments a 5-bit beat counter.
  - `out_last` is tagged on the beat carrying `rlast`.
  - On an accepted beat with `rlast`=1: pulse `done` and return to IDLE.
- **Error accumulation:** a transaction error flag is ORed on every accepted beat where:
  - `rresp` != 0, or
  - `rid` != AXI_ID, or
  - `rlast`=1 and count != len, or
  - `rlast`=0 and count == len.
  
  After the expected count is reached, extra beats are still accepted and delivered until `rlast` arrives. `done` reports the accumulated `err`.
- **FIFO:** standard synchronous FIFO.
  - Push and pop may occur in the same cycle when it is full, because a pop frees a slot.
  - `out_valid` = !empty. `out_data` and `out_last` come from the head entry and stay stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `req_ready`=0 during reset, then 1 in IDLE the cycle after release.
  - `arvalid`=0, `rready`=0, `out_valid`=0, `done`=0, `err`=0.
  - `araddr`, `arlen`, `arid` = 0.
  - `arsize`=3'b010 and `arburst`=2'b01 (constants).
  - FIFO empty, state IDLE.
- Request accepted at edge N: CHK during cycle N+1; `arvalid` rises at N+2.
- R beat accepted at edge M: `out_valid` high from M+1. A word therefore appears on the output 1 cycle after the R handshake.
- Last beat accepted at edge M: `done` is high during cycle M+1, and state is IDLE at M+1.
- `arvalid` is never dropped before `arready`. `rready` may toggle freely.
- Reset mid-operation clears the state, the FIFO and all outputs on the next edge. The partial burst is abandoned; the DRAM side is reset by the same reset.
- Throughput: 1 beat per cycle when `out_ready`=1 continuously.

## Structure
- Package `dram_rd_pkg` holds:
  - the state enum (IDLE/CHK/ADDR/DATA);
  - `AXSIZE_4B`=3'b010 and `BURST_INCR`=2'b01;
  - `RESP_OKAY`=2'b00;
  - `BOUNDARY_4K`=4096.
- Sub-module `dram_rd_fifo`: parameterized synchronous FIFO, DATA_WIDTH+1 bits wide so it carries the last tag, with full, empty and simultaneous push/pop.
- Top level: FSM, beat counter, error accumulation, AXI drive.

## Test plan
- **Basic burst:** addr 0x0001_0000, len 15, DRAM answers in order with OKAY, `out_ready`=1.
  - Expect AR with araddr 0x0001_0000 and arlen 15.
  - Expect 16 words equal to DRAM[0x10000..0x1003C].
  - `out_last` on word 16; `done`=1 with `err`=0 one cycle after the last R beat.
- **4 KB crossing:** addr 0x0000_0FF8, len 3.
  - Expect no `arvalid`; `done`=1 with `err`=1 two cycles after acceptance.
- **Back-pressure:** len 7 with `out_ready`=0 for 10 cycles.
  - `rready` drops after 4 beats, with the FIFO full.
  - Releasing `out_ready` delivers all 8 words in order, none lost or duplicated.
- **Error response:** len 1, beat 0 with `rresp`=2'b10.
  - Both words are delivered; `done` with `err`=1.
- **Protocol errors:**
  - len 3, DRAM asserts `rlast` on beat 2: transaction ends after 3 words with `err`=1.
  - len 0, `rid`=5: `err`=1.
- **Reset and AR stall:**
  - `rst_n`=1 asserted during DATA: next cycle all outputs are at reset values and the FIFO is empty; a new len-0 request then completes normally.
  - `arready` held low for 20 cycles: `araddr` and `arlen` stay stable throughout.
